// File: rtl/mem_pkg.sv
// Shared types and constants for the memory read sequencer: FSM states, MemCmd bit map, data width.
package mem_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  localparam int CMD_SLV0 = 0;
  localparam int CMD_SEL  = 1;
  localparam int CMD_RSVD = 2;
  localparam int CMD_SLV1 = 3;
  localparam int DATA_W   = 32;
endpackage

// File: rtl/mem_settle_timer.sv
// 8-bit loadable down-counter; o_done flags the last cycle of the window (count == 1).
module mem_settle_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_value,
  output logic       o_done
);
  logic [7:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_done = (r_count == 8'd1);
endmodule

// File: rtl/mem_read_sequencer.sv
// Single-request MemCmd/MemData read sequencer with valid/ready request and response ports.
// Optional even-parity output on the response is enabled by defining MEM_RD_PARITY_EN.
module mem_read_sequencer
  import mem_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_sel,
  input  logic [1:0]        i_req_slave,
  output logic [3:0]        o_mem_cmd,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data
`ifdef MEM_RD_PARITY_EN
  ,
  output logic              o_rsp_parity
`endif
);
  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sel;
  logic [1:0]        r_slave;
  logic [3:0]        r_mem_cmd;
  logic [3:0]        w_cmd_nxt;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_accept;
  logic              w_load;
  logic              w_done;
  logic              w_sel;

  // Ready is combinational so the first post-reset cycle can already accept.
  assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_sel       = (r_state == ST_IDLE) ? i_req_sel : r_sel;

  mem_settle_timer u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_value (SETTLE_CNT),
    .o_done  (w_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP: begin
        w_load      = 1'b1;
        w_state_nxt = ST_STROBE;
      end
      ST_STROBE:  if (w_done) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_RESP;
      ST_RESP:    if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // MemCmd is computed from the next state so the bus itself is a clean register output.
  always_comb begin
    w_cmd_nxt = 4'b0000;
    case (w_state_nxt)
      ST_SETUP: w_cmd_nxt[CMD_SEL] = w_sel;
      ST_STROBE, ST_CAPTURE: begin
        w_cmd_nxt[CMD_SEL]  = r_sel;
        w_cmd_nxt[CMD_SLV1] = r_slave[1];
        w_cmd_nxt[CMD_SLV0] = r_slave[0];
      end
      default: w_cmd_nxt = 4'b0000;
    endcase
    w_cmd_nxt[CMD_RSVD] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_mem_cmd  <= 4'b0000;
      r_sel      <= 1'b0;
      r_slave    <= 2'b00;
      r_rsp_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_cmd <= w_cmd_nxt;
      if (w_accept) begin
        r_sel   <= i_req_sel;
        r_slave <= i_req_slave;
      end
      if (r_state == ST_CAPTURE) r_rsp_data <= i_mem_data;
    end
  end

`ifdef MEM_RD_PARITY_EN
  logic r_rsp_parity;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_parity <= 1'b0;
    end else if (r_state == ST_CAPTURE) begin
      r_rsp_parity <= ^i_mem_data;
    end
  end

  assign o_rsp_parity = r_rsp_parity;
`endif

  assign o_mem_cmd   = r_mem_cmd;
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_mem_read_sequencer.sv
// Directed bench for mem_read_sequencer: reset, P/N reads, backpressure, mid-strobe reset, back-to-back.
module tb_mem_read_sequencer;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_sel;
  logic [1:0]  req_slave;
  logic [3:0]  mem_cmd;
  logic [31:0] mem_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] data_p;
  logic [31:0] data_n;
`ifdef MEM_RD_PARITY_EN
  logic        rsp_parity;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Memory manager model: the source-select bit of MemCmd picks the returned word.
  assign mem_data = mem_cmd[1] ? data_n : data_p;

  mem_read_sequencer #(.SETTLE(SETTLE)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_sel   (req_sel),
    .i_req_slave (req_slave),
    .o_mem_cmd   (mem_cmd),
    .i_mem_data  (mem_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data)
`ifdef MEM_RD_PARITY_EN
    ,
    .o_rsp_parity(rsp_parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_read(input logic sel, input logic [1:0] slv,
                          input logic [3:0] exp_setup, input logic [3:0] exp_strobe,
                          input logic [31:0] exp_data, input logic exp_par, input int bp);
    req_valid = 1'b1;
    req_sel   = sel;
    req_slave = slv;
    rsp_ready = (bp == 0);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    req_sel   = ~sel;
    req_slave = ~slv;
    chk("setup_cmd", {28'd0, mem_cmd}, {28'd0, exp_setup});
    chk("setup_ready", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < SETTLE + 1; i++) begin
      tick();
      chk("strobe_cmd", {28'd0, mem_cmd}, {28'd0, exp_strobe});
      chk("strobe_rspv", {31'd0, rsp_valid}, 32'd0);
    end
    tick();
    for (int i = 0; i < bp; i++) begin
      chk("bp_rspv", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, exp_data);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_cmd", {28'd0, mem_cmd}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_data", rsp_data, exp_data);
    chk("resp_cmd", {28'd0, mem_cmd}, 32'd0);
`ifdef MEM_RD_PARITY_EN
    chk("resp_parity", {31'd0, rsp_parity}, {31'd0, exp_par});
`else
    if (exp_par === 1'bx) $display("unexpected parity value");
`endif
    tick();
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rspv", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int cyc;
    int nacc;
    int nrsp;
    int acc_cyc[2];
    logic [31:0] rsp_seen[2];
    logic acc_now;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_sel   = 1'b0;
    req_slave = 2'b00;
    rsp_ready = 1'b1;
    data_p    = 32'hA5A5_0001;
    data_n    = 32'h0000_00FF;

    for (int i = 0; i < 3; i++) tick();
    chk("rst_cmd", {28'd0, mem_cmd}, 32'd0);
    chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'd0, req_ready}, 32'd1);
    tick();

    run_read(1'b0, 2'b01, 4'b0000, 4'b0001, 32'hA5A5_0001, 1'b1, 0);
    run_read(1'b1, 2'b10, 4'b0010, 4'b1010, 32'h0000_00FF, 1'b0, 0);
    data_p = 32'h0000_0007;
    run_read(1'b0, 2'b00, 4'b0000, 4'b0000, 32'h0000_0007, 1'b1, 10);
    data_p = 32'hA5A5_0001;

    // Reset during the second strobe cycle.
    req_valid = 1'b1;
    req_sel   = 1'b1;
    req_slave = 2'b11;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_strobe1", {28'd0, mem_cmd}, 32'd11);
    tick();
    chk("mid_strobe2", {28'd0, mem_cmd}, 32'd11);
    rst = 1'b1;
    tick();
    chk("mid_rst_cmd", {28'd0, mem_cmd}, 32'd0);
    chk("mid_rst_rspv", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_rst_norsp", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_idle", {31'd0, req_ready}, 32'd1);
    end

    // Back-to-back requests with ReqValid held high.
    cyc  = 0;
    nacc = 0;
    nrsp = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    rsp_seen[0] = 32'd0;
    rsp_seen[1] = 32'd0;
    req_valid = 1'b1;
    req_sel   = 1'b0;
    req_slave = 2'b01;
    rsp_ready = 1'b1;
    while (cyc < 60 && nrsp < 2) begin
      if (rsp_valid) begin
        rsp_seen[nrsp] = rsp_data;
        nrsp++;
      end
      acc_now = req_ready && req_valid;
      if (acc_now && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        req_sel = 1'b1;
        if (nacc == 2) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", nacc, 32'd2);
    chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], SETTLE + 4);
    chk("b2b_rsps", nrsp, 32'd2);
    chk("b2b_data0", rsp_seen[0], 32'hA5A5_0001);
    chk("b2b_data1", rsp_seen[1], 32'h0000_00FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_read_sequencer.md
# mem_read_sequencer

Drives the 4-bit `MemCmd` bus into the memory manager and collects the 32-bit `MemData` word it returns. Accepts one read request at a time on a valid/ready port, selects the P or N data source, asserts the slave strobes for a programmable settle window, and captures the word. Presents the captured word on a valid/ready response port. Sits between the encoder-tester control logic and the memory manager.

## Interface
- `SETTLE`, default 2: number of cycles the strobes are held before capture; legal range 1..255.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ReqValid` in 1: request present.
- `ReqReady` out 1: sequencer idle and able to accept.
- `ReqSel` in 1: 0 selects source P, 1 selects source N.
- `ReqSlave` in 2: bit1 drives slave line 1, bit0 drives slave line 0.
- `MemCmd` out 4: bit1 source select, bit3 slave-1 strobe, bit0 slave-0 strobe, bit2 always 0.
- `MemData` in 32: word returned by the memory manager.
- `RspValid` out 1: captured word available.
- `RspReady` in 1: consumer takes the word.
- `RspData` out 32: captured word.
- `RspParity` out 1: even parity of `RspData`; present only with `MEM_RD_PARITY_EN`.

## Operation
- States: IDLE, SETUP, STROBE, CAPTURE, RESP.
- IDLE: `ReqReady`=1, `MemCmd`=0. On `ReqValid`&`ReqReady`, latch `ReqSel`/`ReqSlave` and go to SETUP.
- SETUP (1 cycle): `MemCmd[1]`=sel; strobes 0; load settle counter with `SETTLE`.
- STROBE (`SETTLE` cycles): `MemCmd[1]`=sel, `MemCmd[3]`=slave[1], `MemCmd[0]`=slave[0]. The counter decrements each cycle; at 1 the state goes to CAPTURE.
- CAPTURE (1 cycle): strobes still asserted; `MemData` is registered into `RspData` at the end of the cycle; go to RESP.
- RESP: `RspValid`=1 and `RspData` held stable; `MemCmd`=0. When `RspReady`=1, go to IDLE.
- `ReqSlave`=2'b00 is legal: no strobe is raised, and the sequence and timing are unchanged.
- `ReqReady` is 0 in every state except IDLE. Requests are never queued.

## Timing
- Reset values: state IDLE, `MemCmd`=4'b0000, `RspValid`=0, `RspData`=0, `RspParity`=0. `ReqReady`=0 while `rst` is high and 1 on the first cycle after `rst` falls.
- Accept at edge T. Cycle T+1 is SETUP. Cycles T+2..T+1+`SETTLE` are STROBE. Cycle T+2+`SETTLE` is CAPTURE. `RspValid` rises at T+3+`SETTLE`.
- Minimum request-to-request period is `SETTLE`+4 cycles, reached when `RspReady` is held high. The next accept occurs in the cycle after the RESP handshake.
- `MemCmd` is fully registered. There is no glitch between the source-select change and the strobe rise, because select leads the strobes by one cycle.
- `RspValid` stays high with `RspData` stable until the handshake completes. Backpressure of any length is allowed.
- `rst` in any state: return to IDLE on the next edge, clear all outputs, and drop any captured word.
- Inputs sampled outside IDLE (`ReqSel`, `ReqSlave`) are ignored.

## Configuration
- `MEM_RD_PARITY_EN` defined: the `RspParity` port exists and is registered together with `RspData` in CAPTURE. Its value is XOR of all 32 bits, so `RspParity` is 1 when the captured word has an odd number of 1s.
- `MEM_RD_PARITY_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, SETUP, STROBE, CAPTURE, RESP);
  - `MemCmd` bit-index constants (SEL=1, SLV1=3, SLV0=0, RSVD=2);
  - data width constant 32.
- Sub-module `mem_settle_timer`: 8-bit loadable down-counter with `load`, `value`, and `done` signals (`done` when count==1). The FSM instantiates it once.

## Test plan
- Reset then idle: hold `rst` 3 cycles -> `MemCmd`=0, `RspValid`=0, and `ReqReady`=1 on the first cycle after release.
- P read, `SETTLE`=2, sel=0, slave=2'b01, `MemDataP`=32'hA5A5_0001, `RspReady`=1:
  - `MemCmd`=4'b0000 in SETUP, then 4'b0001 for 3 cycles;
  - `RspValid` at T+5 with `RspData`=32'hA5A5_0001.
- N read, sel=1, slave=2'b10, `MemDataN`=32'h0000_00FF:
  - `MemCmd`=4'b0010 in SETUP, then 4'b1010;
  - `RspData`=32'h0000_00FF;
  - `RspParity`=0 when the macro is defined.
- Backpressure: hold `RspReady`=0 for 10 cycles -> `RspValid` and `RspData` stable, `ReqReady`=0, `MemCmd`=0. Handshake on cycle 11, then `ReqReady`=1 on the following cycle.
- Reset mid-STROBE: assert `rst` during the second STROBE cycle -> next edge gives `MemCmd`=0, no `RspValid` ever, and the sequencer returns to IDLE.
- Back-to-back: `ReqValid` held high for two requests with `RspReady`=1 -> accepts spaced exactly `SETTLE`+4 cycles apart, and both responses carry the correct data.
